pri_arb_rr_n: RTL

//  Parametrised N-requester arbiter: successor to the combinational 8:3 priority encoder.

---
 rtl/pri_arb_rr_n_if.sv | 24 ++
 rtl/pri_arb_rr_n.sv | 99 +++++++++
 2 files changed

// File: rtl/pri_arb_rr_n_if.sv
// Request/grant bundle between N bus masters and the arbiter.
// The master side drives requests; the slave side (arbiter) drives the grant.
interface pri_arb_rr_n_if #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic          mode;
    logic          release_gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_onehot;
    logic          timeout;

    modport master (
        output req, mode, release_gnt,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout
    );

    modport slave (
        input  req, mode, release_gnt,
        output gnt_valid, gnt_idx, gnt_onehot, timeout
    );
endinterface

// File: rtl/pri_arb_rr_n.sv
// N-requester arbiter with a registered, held grant.
// Fixed (highest index) or round-robin selection, with optional hold timeout.
module pri_arb_rr_n #(
    parameter int  N        = 8,
    parameter int  MAX_HOLD = 16,
    localparam int IW       = $clog2(N),
    localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input logic          clk,
    input logic          rst,
    pri_arb_rr_n_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    logic [IW-1:0] win;
    logic          found;
    logic          owner_req;
    logic          expired;
    int            j;

    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[IW'(i)]) win = IW'(i);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= N) j = j - N;
                if (!found && bus.req[IW'(j)]) begin
                    found = 1'b1;
                    win   = IW'(j);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        owner_req  = bus.req[gnt_idx_q];
        expired    = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = GRANT;
                    gnt_idx_d  = win;
                    hold_cnt_d = HW'(1);
                end
            end
            GRANT: begin
                if (bus.release_gnt || !owner_req || expired) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    // release or request drop outranks the timeout flag
                    timeout_d  = expired && !bus.release_gnt && owner_req;
                    rr_ptr_d   = (gnt_idx_q == IW'(N - 1)) ? '0
                                                          : gnt_idx_q + 1'b1;
                end else if (MAX_HOLD != 0) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt_valid  = (state_q == GRANT);
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_onehot = (state_q == GRANT) ? (N'(1) << gnt_idx_q) : '0;
    assign bus.timeout    = timeout_q;
endmodule
